data_memory_stream_reader: RTL and testbench

Avalon-MM read master for the 4096x32 single-port on-chip data memory.
- Accepts a command (start word address, word count) and issues sequential reads to the memory.
- Captures the fixed-latency read data and presents it as a valid/ready stream to downstream encryption datapath logic.
- Acts as the initiator and consumer end of the data-memory slave interface. It never writes to the memory.

---
 rtl/ted_mem_pkg.sv | 25 ++
 rtl/ted_sync_fifo.sv | 60 ++++++
 rtl/data_memory_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_data_memory_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ted_mem_pkg.sv
// Shared types and sizes for the on-chip data memory and its read master.
// Imported by the stream reader and its output buffer.
package ted_mem_pkg;

  localparam int DMEM_ADDR_W       = 12;
  localparam int DMEM_DATA_W       = 32;
  localparam int DMEM_WORDS        = 4096;
  localparam int DMEM_READ_LATENCY = 1;
  localparam int DMEM_LEN_W        = 13;
  localparam int DMEM_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;

  // Memory word address after a step, wrapping at the top of memory.
  function automatic logic [DMEM_ADDR_W-1:0] dmem_next_addr(
    input logic [DMEM_ADDR_W-1:0] addr
  );
    return addr + DMEM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ted_sync_fifo.sv
// Show-ahead synchronous FIFO: head word visible on rd_data while not empty.
// Power-of-two depth; count, empty and full derive from one occupancy counter.
module ted_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = store[rd_ptr];

  // Storage array needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      store[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a write and a read together leave count as is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_stream_reader.sv
// Avalon-MM read master: streams a block of data-memory words downstream.
// Reads are credit-limited so the output buffer can never overflow.
module data_memory_stream_reader
  import ted_mem_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int LEN_W        = DMEM_LEN_W,
  parameter int FIFO_DEPTH   = DMEM_FIFO_DEPTH,
  parameter int READ_LATENCY = DMEM_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + READ_LATENCY) + 1;

  rd_state_e state_q;
  rd_state_e state_d;

  logic [ADDR_W-1:0]       rd_addr;
  logic [LEN_W-1:0]        issue_rem;
  logic [LEN_W-1:0]        deliver_rem;
  logic                    done_q;
  logic [READ_LATENCY-1:0] tag_pipe;
  logic                    tag_exit;

  logic             cmd_fire;
  logic             issue;
  logic             pop;
  logic             has_credit;
  logic [CRD_W-1:0] credit_used;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;

  assign cmd_ready      = reset_n && (state_q == IDLE);
  assign cmd_fire       = cmd_valid && cmd_ready;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

  assign avm_chipselect = issue;
  assign avm_address    = rd_addr;

  assign tag_exit       = tag_pipe[READ_LATENCY-1];
  assign st_valid       = !fifo_empty;
  assign pop            = st_valid && st_ready;
  assign st_last        = st_valid && (deliver_rem == LEN_W'(1));

  // Words already buffered plus reads still in the memory pipe.
  always_comb begin
    credit_used = CRD_W'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      credit_used = credit_used + CRD_W'(tag_pipe[i]);
    end
    has_credit = (credit_used < CRD_W'(FIFO_DEPTH));
  end

  // Next state and read strobe.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire && (cmd_len != '0)) begin
          state_d = READ;
        end
      end
      READ: begin
        issue = has_credit && (issue_rem != '0);
        if (issue && (issue_rem == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (deliver_rem == LEN_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address and remaining-word counters for issue and delivery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr     <= '0;
      issue_rem   <= '0;
      deliver_rem <= '0;
    end else if (cmd_fire) begin
      rd_addr     <= cmd_addr;
      issue_rem   <= cmd_len;
      deliver_rem <= cmd_len;
    end else begin
      if (issue) begin
        rd_addr   <= dmem_next_addr(rd_addr);
        issue_rem <= issue_rem - LEN_W'(1);
      end
      if (pop) begin
        deliver_rem <= deliver_rem - LEN_W'(1);
      end
    end
  end

  // Completion pulse: empty command, or last word taken downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (cmd_fire && (cmd_len == '0)) ||
                (pop && (deliver_rem == LEN_W'(1)));
    end
  end

  // Strobe tags travel alongside the memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  ted_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (tag_exit && !fifo_full),
    .wr_data (avm_readdata),
    .rd_en   (pop),
    .rd_data (st_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_data_memory_stream_reader.sv
// Scoreboard bench for data_memory_stream_reader with a behavioural memory.
// Stimulus queues expected strobes/words; a negedge monitor checks them.
module tb_data_memory_stream_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [12:0] cmd_len;
  logic        busy;
  logic        done;
  logic [11:0] avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_clken;
  logic [31:0] avm_readdata;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;
  logic        st_last;

  logic [31:0] mem [4096];
  exp_t        exp_q [$];
  logic [11:0] exp_addr_q [$];
  int          vis_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issued = 0;
  int popped = 0;
  int delivered = 0;
  int ready_mode = 1;

  bit          exp_busy = 0;
  bit          exp_done = 0;
  bit          done_pend = 0;
  bit          hs_pend = 0;
  logic [12:0] hs_len = '0;
  bit          held = 0;
  logic [31:0] held_data = '0;
  bit          exp_cs;
  bit          exp_valid;
  bit          exp_last;
  exp_t        e;

  always #5 clk = ~clk;

  data_memory_stream_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_last        (st_last)
  );

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) avm_readdata <= mem[avm_address];

  // Downstream ready: held low, held high, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       st_ready = 1'b0;
      1:       st_ready = 1'b1;
      default: st_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: a word issued in cycle c is visible from c+2; credit of 4.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_cs", 32'(avm_chipselect), 32'(0));
      chk("rst_addr", 32'(avm_address), 32'(0));
      chk("rst_valid", 32'(st_valid), 32'(0));
      chk("rst_last", 32'(st_last), 32'(0));
      exp_busy = 0;
      done_pend = 0;
      hs_pend = 0;
      issued = 0;
      popped = 0;
      held = 0;
      vis_q.delete();
    end else begin
      exp_done = done_pend;
      done_pend = 0;
      if (exp_done) exp_busy = 0;
      if (hs_pend) begin
        if (hs_len == 0) exp_done = 1;
        else exp_busy = 1;
        hs_pend = 0;
      end
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
      chk("avm_write", 32'(avm_write), 32'(0));
      chk("byteenable", 32'(avm_byteenable), 32'(4'hF));
      chk("clken", 32'(avm_clken), 32'(1));
      exp_cs = exp_busy && (exp_addr_q.size() != 0) && (issued - popped < 4);
      chk("chipselect", 32'(avm_chipselect), 32'(exp_cs));
      if (avm_chipselect) begin
        if (exp_addr_q.size() != 0)
          chk("address", 32'(avm_address), 32'(exp_addr_q.pop_front()));
        issued++;
        vis_q.push_back(cyc + 2);
      end
      exp_valid = (vis_q.size() != 0) && (vis_q[0] <= cyc);
      chk("st_valid", 32'(st_valid), 32'(exp_valid));
      if (held) chk("hold_data", st_data, held_data);
      exp_last = st_valid && (exp_q.size() != 0) && exp_q[0].last;
      chk("st_last", 32'(st_last), 32'(exp_last));
      if (st_valid && st_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("st_data", st_data, e.data);
          if (e.last) done_pend = 1;
        end else begin
          chk("unexpected_word", 32'(st_valid), 32'(0));
        end
        popped++;
        delivered++;
        if (vis_q.size() != 0) void'(vis_q.pop_front());
      end
      held = st_valid && !st_ready;
      held_data = st_data;
      if (cmd_valid && cmd_ready) begin
        hs_pend = 1;
        hs_len = cmd_len;
      end
    end
  end

  task automatic send(input logic [11:0] a, input logic [12:0] n);
    int k;
    logic [11:0] ad;
    k = 0;
    while (!cmd_ready) begin
      @(posedge clk);
      #1;
      k++;
      if (k > 6000) begin
        $display("FAIL cmd_ready_timeout: got 0 expected 1");
        $fatal(1, "timeout");
      end
    end
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = n;
    for (int i = 0; i < int'(n); i++) begin
      ad = 12'(int'(a) + i);
      exp_addr_q.push_back(ad);
      exp_q.push_back('{data: mem[ad], last: (i == int'(n) - 1)});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (exp_q.size() != 0 || exp_busy || hs_pend || done_pend ||
           !cmd_ready) begin
      @(posedge clk);
      #1;
      k++;
      if (k > lim) begin
        $display("FAIL idle_timeout: got %0d words left expected 0",
                 exp_q.size());
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin
    int base;
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0A0_0000 + 32'(i);
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    send(12'h010, 13'd4);
    wait_idle(100);
    send(12'hFFE, 13'd4);
    wait_idle(100);
    send(12'h055, 13'd0);
    wait_idle(100);
    send(12'hFFF, 13'd1);
    wait_idle(100);

    ready_mode = 0;
    send(12'h300, 13'd16);
    repeat (20) @(posedge clk);
    #1;
    ready_mode = 1;
    wait_idle(200);

    ready_mode = 2;
    send(12'h123, 13'd12);
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = 12'h456;
    cmd_len = 13'd5;
    repeat (4) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle(400);

    for (int n = 0; n < 20; n++) begin
      ready_mode = (n % 3 == 0) ? 1 : 2;
      send((n % 4 == 0) ? 12'(12'hFF0 + $urandom_range(0, 15))
                        : 12'($urandom),
           13'($urandom_range(0, 24)));
      wait_idle(400);
    end

    ready_mode = 1;
    base = delivered;
    send(12'h700, 13'd100);
    k = 0;
    while (delivered < base + 10) begin
      @(posedge clk);
      #1;
      k++;
      if (k > 200) begin
        $display("FAIL burst_timeout: got %0d expected 10", delivered - base);
        $fatal(1, "timeout");
      end
    end
    reset_n = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(12'h200, 13'd2);
    wait_idle(100);

    send(12'h800, 13'd4096);
    wait_idle(6000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
